alu_exec_ctrl: RTL
==================

# alu_exec_ctrl

Single-issue execution controller that sequences the 10-bit signed ALU of the course-work processor. It accepts one decoded instruction at a time and fetches operands from an internal 8×10 register file or from data memory. It then drives the ALU, writes the result back and registers the S/G flags. It sits between the instruction decoder and the ALU/data-memory port.

## Interface
- `NREGS`, 8: register count; address width = $clog2(NREGS)
- `AW`, 8: data-memory address width
- `clk  in  1  system clock, rising edge`
- `rst_n  in  1  reset, asynchronous, active-low`
- `instr_valid  in  1  decoder offers an instruction`
- `instr_ready  out  1  controller can accept; transfer on valid & ready`
- `instr_op  in  5  opcode`
- `instr_rd  in  3  destination / first source register`
- `instr_rs  in  3  second source register`
- `instr_addr  in  AW  memory operand address`
- `alu_opcode  out  5  to ALU`
- `alu_op1, alu_op2  out  10  ALU operands, signed`
- `alu_res  in  10  ALU result, signed`
- `alu_s, alu_g  in  1  ALU sign / greater flags`
- `mem_req  out  1  read request, held until mem_ack`
- `mem_addr  out  AW  read address, stable while mem_req`
- `mem_ack  in  1  read complete; mem_rdata valid this cycle`
- `mem_rdata  in  10  read data`
- `flag_s, flag_g  out  1  registered flags`
- `done  out  1  one-cycle pulse: instruction retired`
- `illegal  out  1  one-cycle pulse: unsupported opcode rejected`
- `dbg_addr  in  3  debug register select`
- `dbg_data  out  10  combinational read of R[dbg_addr]`

## Operation
- Opcode classes:
  - 00001 LOAD: R[rd] ← mem[addr]; flags unchanged; ALU not used.
  - Reg forms: 00101 DEC, 00111 XOR, 01001 NAND, 01011 ROT, 10011 INC.
  - Mem forms: 00110 DEC, 01000 XOR, 01010 NAND, 01100 ROT.
  - Everything else is illegal.
- Operand selection:
  - Binary ops (XOR/NAND/ROT): op1 = R[rd]; op2 = R[rs] (reg form) or mem data (mem form).
  - Unary ops (DEC/INC): op1 = R[rs] or mem data; op2 = 0.
  - Result is always written to R[rd].
- alu_opcode = latched opcode in EXEC; 00000 otherwise. Operands are 0 outside EXEC.
- FSM:
  - IDLE: instr_ready=1. On accept, latch op/rd/rs/addr.
    - Illegal opcode: pulse illegal next cycle, stay IDLE.
    - Reg form: go to EXEC.
    - LOAD or mem form: go to MEM.
  - MEM: mem_req=1, mem_addr=latched addr. On mem_ack, capture mem_rdata.
    - LOAD: go to WB.
    - Mem form: go to EXEC.
  - EXEC: drive ALU. At the end of the cycle: R[rd] ← alu_res, flag_s ← alu_s, flag_g ← alu_g. done=1. Next state IDLE.
  - WB (LOAD only): R[rd] ← captured data, done=1, next state IDLE.
- instr_ready=0 in every state except IDLE. Exactly one instruction is in flight.
- Arithmetic wraps at 10 bits with no saturation. INC of 511 gives -512.

## Timing
- Reset values: instr_ready=0 while rst_n is low and 1 from the first edge after release. mem_req, done, illegal, flag_s, flag_g = 0. All registers = 0. State = IDLE.
- Reg form accepted at edge T: EXEC and done in cycle T+1; result visible on dbg_data from T+2; next accept possible at T+2.
- Mem form accepted at T: mem_req asserted from T+1 through the ack cycle A. EXEC/done at A+1.
- LOAD: WB/done at A+1.
- mem_ack in the first mem_req cycle is legal: mem form completes at T+2.
- mem_ack while mem_req=0 is ignored.
- illegal pulses in cycle T+1; instr_ready stays 1.
- Asynchronous reset in any state:
  - mem_req, done and illegal drop immediately.
  - The in-flight instruction is discarded.
  - The register file and flags clear.
- dbg_data is combinational and reflects the write one cycle after EXEC/WB.

## Structure
- Shared package `sifo_pkg` holds:
  - Opcode localparams: OP_LOAD, OP_DEC_R/M, OP_XOR_R/M, OP_NAND_R/M, OP_ROT_R/M, OP_INC.
  - The FSM state enum (IDLE, MEM, EXEC, WB).
  - Data width 10.
- Sub-module `reg_file`: NREGS×10, async reset to 0, one write port, two combinational read ports plus the debug read port.

## Test plan
- Reset:
  - Stimulus: hold rst_n low 3 cycles, then release.
  - Required: all outputs 0 during reset; instr_ready=1 after release; dbg_data=0 for every address.
- LOAD R1 from addr 0x10:
  - Stimulus: memory acks after 3 wait cycles with data 5.
  - Required: mem_req high for exactly 4 cycles with mem_addr=0x10; done one cycle after ack; R1=5; flags unchanged.
- XOR reg form (op 00111, rd=1, rs=2) with R1=5, R2=3:
  - Required: done at T+1, R1=6, flag_s=0, flag_g=1.
- DEC reg form (op 00101, rd=4, rs=3) with R3=0:
  - Required: R4=-1 (10'h3FF), flag_s=1, flag_g=0.
- Illegal opcode 11111:
  - Required: illegal pulse at T+1, no register or flag change, instr_ready stays 1.
  - Follow-up: a back-to-back valid INC (op 10011) is accepted the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst_n low during MEM with mem_req=1.
  - Required: mem_req=0 in the same cycle (asynchronous); after release, state IDLE, R1=0, no done pulse.

Source files
------------

// File: rtl/sifo_pkg.sv
// Shared definitions for the execution controller: opcodes, FSM states,
// and the opcode classifier used when an instruction is accepted.
package sifo_pkg;

   localparam int DW = 10;

   localparam logic [4:0] OP_NOP    = 5'b00000;
   localparam logic [4:0] OP_LOAD   = 5'b00001;
   localparam logic [4:0] OP_DEC_R  = 5'b00101;
   localparam logic [4:0] OP_DEC_M  = 5'b00110;
   localparam logic [4:0] OP_XOR_R  = 5'b00111;
   localparam logic [4:0] OP_XOR_M  = 5'b01000;
   localparam logic [4:0] OP_NAND_R = 5'b01001;
   localparam logic [4:0] OP_NAND_M = 5'b01010;
   localparam logic [4:0] OP_ROT_R  = 5'b01011;
   localparam logic [4:0] OP_ROT_M  = 5'b01100;
   localparam logic [4:0] OP_INC    = 5'b10011;

   typedef enum logic [1:0] {
      IDLE,
      MEM,
      EXEC,
      WB
   } state_e;

   // Operand routing class; decided once at accept time.
   typedef enum logic [2:0] {
      CLS_ILLEGAL,
      CLS_LOAD,
      CLS_REG_BIN,
      CLS_REG_UN,
      CLS_MEM_BIN,
      CLS_MEM_UN
   } op_class_e;

   function automatic op_class_e classify(input logic [4:0] op);
      op_class_e cls;
      cls = CLS_ILLEGAL;
      case (op)
         OP_LOAD:                        cls = CLS_LOAD;
         OP_XOR_R, OP_NAND_R, OP_ROT_R:  cls = CLS_REG_BIN;
         OP_DEC_R, OP_INC:               cls = CLS_REG_UN;
         OP_XOR_M, OP_NAND_M, OP_ROT_M:  cls = CLS_MEM_BIN;
         OP_DEC_M:                       cls = CLS_MEM_UN;
         default:                        cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/reg_file.sv
// NREGS x 10-bit register file: one write port, two operand read ports and
// a debug read port, all reads combinational, cleared by async reset.
module reg_file
   import sifo_pkg::*;
#(
   parameter  int NREGS = 8,
   localparam int RAW   = $clog2(NREGS)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           we_i,
   input  logic [RAW-1:0] waddr_i,
   input  logic [DW-1:0]  wdata_i,
   input  logic [RAW-1:0] raddr_a_i,
   input  logic [RAW-1:0] raddr_b_i,
   input  logic [RAW-1:0] dbg_addr_i,
   output logic [DW-1:0]  rdata_a_o,
   output logic [DW-1:0]  rdata_b_o,
   output logic [DW-1:0]  dbg_data_o
);

   logic [DW-1:0] regs_q [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o  = regs_q[raddr_a_i];
   assign rdata_b_o  = regs_q[raddr_b_i];
   assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Single-issue execution controller: accepts one decoded instruction, fetches
// operands from the register file or data memory, drives the ALU, writes back.
module alu_exec_ctrl
   import sifo_pkg::*;
#(
   parameter  int NREGS = 8,
   parameter  int AW    = 8,
   localparam int RAW   = $clog2(NREGS)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           instr_valid,
   output logic           instr_ready,
   input  logic [4:0]     instr_op,
   input  logic [RAW-1:0] instr_rd,
   input  logic [RAW-1:0] instr_rs,
   input  logic [AW-1:0]  instr_addr,
   output logic [4:0]     alu_opcode,
   output logic [DW-1:0]  alu_op1,
   output logic [DW-1:0]  alu_op2,
   input  logic [DW-1:0]  alu_res,
   input  logic           alu_s,
   input  logic           alu_g,
   output logic           mem_req,
   output logic [AW-1:0]  mem_addr,
   input  logic           mem_ack,
   input  logic [DW-1:0]  mem_rdata,
   output logic           flag_s,
   output logic           flag_g,
   output logic           done,
   output logic           illegal,
   input  logic [RAW-1:0] dbg_addr,
   output logic [DW-1:0]  dbg_data
);

   state_e         state_q, state_d;
   op_class_e      cls_q, cls_d;
   logic [4:0]     op_q, op_d;
   logic [RAW-1:0] rd_q, rd_d;
   logic [RAW-1:0] rs_q, rs_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [DW-1:0]  mdata_q, mdata_d;
   logic           illegal_q, illegal_d;
   logic           ready_en_q;
   logic           flag_s_q, flag_g_q;

   logic           rf_we;
   logic [DW-1:0]  rf_wdata;
   logic [DW-1:0]  rf_rdata_a, rf_rdata_b;
   logic           flag_we;

   reg_file #(
      .NREGS (NREGS)
   ) u_reg_file (
      .clk        (clk),
      .rst_n      (rst_n),
      .we_i       (rf_we),
      .waddr_i    (rd_q),
      .wdata_i    (rf_wdata),
      .raddr_a_i  (rd_q),
      .raddr_b_i  (rs_q),
      .dbg_addr_i (dbg_addr),
      .rdata_a_o  (rf_rdata_a),
      .rdata_b_o  (rf_rdata_b),
      .dbg_data_o (dbg_data)
   );

   // ready_en_q holds instr_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cls_q      <= CLS_ILLEGAL;
         op_q       <= OP_NOP;
         rd_q       <= '0;
         rs_q       <= '0;
         addr_q     <= '0;
         mdata_q    <= '0;
         illegal_q  <= 1'b0;
         ready_en_q <= 1'b0;
         flag_s_q   <= 1'b0;
         flag_g_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cls_q      <= cls_d;
         op_q       <= op_d;
         rd_q       <= rd_d;
         rs_q       <= rs_d;
         addr_q     <= addr_d;
         mdata_q    <= mdata_d;
         illegal_q  <= illegal_d;
         ready_en_q <= 1'b1;
         if (flag_we) begin
            flag_s_q <= alu_s;
            flag_g_q <= alu_g;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cls_d       = cls_q;
      op_d        = op_q;
      rd_d        = rd_q;
      rs_d        = rs_q;
      addr_d      = addr_q;
      mdata_d     = mdata_q;
      illegal_d   = 1'b0;
      instr_ready = 1'b0;
      mem_req     = 1'b0;
      done        = 1'b0;
      alu_opcode  = OP_NOP;
      alu_op1     = '0;
      alu_op2     = '0;
      rf_we       = 1'b0;
      rf_wdata    = '0;
      flag_we     = 1'b0;

      case (state_q)
         IDLE: begin
            instr_ready = ready_en_q;
            if (instr_valid && ready_en_q) begin
               op_d   = instr_op;
               rd_d   = instr_rd;
               rs_d   = instr_rs;
               addr_d = instr_addr;
               cls_d  = classify(instr_op);
               case (classify(instr_op))
                  CLS_ILLEGAL:            illegal_d = 1'b1;
                  CLS_REG_BIN, CLS_REG_UN: state_d  = EXEC;
                  default:                state_d   = MEM;
               endcase
            end
         end

         MEM: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               mdata_d = mem_rdata;
               state_d = (cls_q == CLS_LOAD) ? WB : EXEC;
            end
         end

         EXEC: begin
            done       = 1'b1;
            alu_opcode = op_q;
            // Binary ops read rd as first source; unary ops take their single source on op1.
            case (cls_q)
               CLS_REG_BIN: begin
                  alu_op1 = rf_rdata_a;
                  alu_op2 = rf_rdata_b;
               end
               CLS_MEM_BIN: begin
                  alu_op1 = rf_rdata_a;
                  alu_op2 = mdata_q;
               end
               CLS_REG_UN:  alu_op1 = rf_rdata_b;
               CLS_MEM_UN:  alu_op1 = mdata_q;
               default:     alu_op1 = '0;
            endcase
            rf_we    = 1'b1;
            rf_wdata = alu_res;
            flag_we  = 1'b1;
            state_d  = IDLE;
         end

         WB: begin
            done     = 1'b1;
            rf_we    = 1'b1;
            rf_wdata = mdata_q;
            state_d  = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign mem_addr = addr_q;
   assign illegal  = illegal_q;
   assign flag_s   = flag_s_q;
   assign flag_g   = flag_g_q;

endmodule
